// File: rtl/tqvp_neuro_nav_pkg.sv
// Shared constants and types for the spiking-neuron navigation array.
// Register map addresses, bus size codes, heading and FSM state enums.
package tqvp_neuro_nav_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h04;
    localparam logic [5:0] ADDR_POS      = 6'h08;
    localparam logic [5:0] ADDR_GEOFENCE = 6'h0C;
    localparam logic [5:0] ADDR_IRQ_CLR  = 6'h10;
    localparam logic [5:0] ADDR_CH_BASE  = 6'h20;

    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    typedef enum logic [1:0] {
        HEAD_POS_X = 2'd0,
        HEAD_POS_Y = 2'd1,
        HEAD_NEG_X = 2'd2,
        HEAD_NEG_Y = 2'd3
    } heading_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_APPLY = 2'd2
    } nav_state_e;

endpackage

// File: rtl/tqvp_neuro_nav_spike_fifo.sv
// Small circular FIFO holding rising-edge spike vectors until the FSM drains them.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tqvp_neuro_nav_spike_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && rst_n && !flush;
    assign do_push = push && (!full || do_pop) && rst_n && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tqvp_neuro_nav_array.sv
// Spike-driven dead-reckoning navigator: each rising spike moves POS along its channel heading.
// Optional weight decay is built only when NEURO_NAV_DECAY_EN is defined.
module tqvp_neuro_nav_array
    import tqvp_neuro_nav_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int WW         = 8,
    parameter int PW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int            FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WW-1:0] WMAX = '1;

    logic             ctrl_enable_q;
    logic             ctrl_learn_q;
    logic             ctrl_ovf_en_q;
    logic [7:0]       decay_period_q;
    logic [15:0]      geofence_q;
    logic [NCH-1:0]   prev_q;
    logic             overflow_q;
    logic             irq_q;

    nav_state_e       state_q;
    logic             busy_q;
    logic [NCH-1:0]   work_q;
    logic [PW-1:0]    pos_x_q;
    logic [PW-1:0]    pos_y_q;

    logic [WW-1:0]    weight_q  [NCH];
    heading_e         heading_q [NCH];

    logic             wr_word;
    logic             wr_any;
    logic             ctrl_wr;
    logic             geo_wr;
    logic             ch_hit;
    logic             ch_wr;
    logic [2:0]       ch_sel;
    logic             clear;
    logic             irq_clr;

    logic [NCH-1:0]   rise;
    logic             push_req;
    logic             fifo_pop;
    logic [NCH-1:0]   fifo_dout;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_event;
    logic             overflow_d;

    logic [2:0]       svc_idx;
    logic [WW-1:0]    svc_weight;
    heading_e         svc_heading;
    logic             svc_valid;
    logic [PW-1:0]    delta;
    logic [NCH-1:0]   work_next;
    logic             decay_tick;

    logic [PW:0]      x_abs;
    logic [PW:0]      y_abs;
    logic             fence_hit;
    logic             irq_set;
    logic             unused_inputs;

    assign wr_word = (data_write_n == SIZE_WORD);
    assign wr_any  = (data_write_n != SIZE_NONE);
    assign ch_sel  = address[4:2];
    assign ch_hit  = address[5] && (int'(ch_sel) < NCH);
    assign ctrl_wr = wr_word && (address == ADDR_CTRL);
    assign geo_wr  = wr_word && (address == ADDR_GEOFENCE);
    assign ch_wr   = wr_word && ch_hit;
    assign clear   = ctrl_wr && data_in[2];
    assign irq_clr = wr_any && (address == ADDR_IRQ_CLR) && data_in[0];

    assign data_ready     = 1'b1;
    assign user_interrupt = irq_q;
    assign uo_out         = {pos_y_q[3:0], pos_x_q[3:0]};
    assign unused_inputs  = &{1'b0, data_read_n, data_in, address[1:0], ui_in};

    // Clear is a strobe, so it has no storage and always reads back as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_enable_q  <= 1'b0;
            ctrl_learn_q   <= 1'b0;
            ctrl_ovf_en_q  <= 1'b0;
            decay_period_q <= 8'd0;
            geofence_q     <= 16'd0;
            prev_q         <= '0;
        end else begin
            prev_q <= ui_in[NCH-1:0];
            if (ctrl_wr) begin
                ctrl_enable_q  <= data_in[0];
                ctrl_learn_q   <= data_in[1];
                ctrl_ovf_en_q  <= data_in[3];
                decay_period_q <= data_in[15:8];
            end
            if (geo_wr) begin
                geofence_q <= data_in[15:0];
            end
        end
    end

    assign rise      = ui_in[NCH-1:0] & ~prev_q;
    assign push_req  = ctrl_enable_q && (rise != '0);
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign ovf_event = push_req && fifo_full && !fifo_pop && !clear;

    tqvp_neuro_nav_spike_fifo #(
        .WIDTH (NCH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (fifo_pop),
        .flush (clear),
        .din   (rise),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Lowest set bit of the work vector is the channel serviced this cycle.
    always_comb begin
        svc_idx     = 3'd0;
        svc_weight  = '0;
        svc_heading = HEAD_POS_X;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (work_q[i]) begin
                svc_idx = 3'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (svc_idx == 3'(i)) begin
                svc_weight  = weight_q[i];
                svc_heading = heading_q[i];
            end
        end
    end

    assign svc_valid = (state_q == ST_APPLY) && !clear;
    assign delta     = PW'(svc_weight);
    assign work_next = work_q & (work_q - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            work_q  <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        work_q  <= fifo_dout;
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_APPLY;
                end
                ST_APPLY: begin
                    case (svc_heading)
                        HEAD_POS_X: pos_x_q <= pos_x_q + delta;
                        HEAD_POS_Y: pos_y_q <= pos_y_q + delta;
                        HEAD_NEG_X: pos_x_q <= pos_x_q - delta;
                        default:    pos_y_q <= pos_y_q - delta;
                    endcase
                    work_q <= work_next;
                    if (work_next == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NEURO_NAV_DECAY_EN
    logic [7:0] decay_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || (decay_period_q == 8'd0) || decay_tick) begin
            decay_cnt_q <= 8'd0;
        end else begin
            decay_cnt_q <= decay_cnt_q + 8'd1;
        end
    end

    assign decay_tick = (decay_period_q != 8'd0) && (decay_cnt_q == decay_period_q);
`else
    assign decay_tick = 1'b0;
`endif

    // Priority per channel: CPU write, then learn increment, then decay.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                weight_q[i]  <= WW'(1);
                heading_q[i] <= heading_e'(i[1:0]);
            end else if (ch_wr && (ch_sel == 3'(i))) begin
                weight_q[i]  <= data_in[WW-1:0];
                heading_q[i] <= heading_e'(data_in[17:16]);
            end else if (svc_valid && ctrl_learn_q && (svc_idx == 3'(i))) begin
                if (weight_q[i] != WMAX) begin
                    weight_q[i] <= weight_q[i] + 1'b1;
                end
            end else if (decay_tick && (weight_q[i] > WW'(1))) begin
                weight_q[i] <= weight_q[i] - 1'b1;
            end
        end
    end

    assign x_abs     = pos_x_q[PW-1] ? ({1'b0, ~pos_x_q} + 1'b1) : {1'b0, pos_x_q};
    assign y_abs     = pos_y_q[PW-1] ? ({1'b0, ~pos_y_q} + 1'b1) : {1'b0, pos_y_q};
    assign fence_hit = (geofence_q != 16'd0) &&
                       ((17'(x_abs) > 17'(geofence_q)) || (17'(y_abs) > 17'(geofence_q)));

    // Using the next overflow value lets IRQ_CLR drop both flags together.
    always_comb begin
        overflow_d = overflow_q;
        if (irq_clr) begin
            overflow_d = 1'b0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
    end

    assign irq_set = fence_hit || (ctrl_ovf_en_q && overflow_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = 32'd0;
        case (address)
            ADDR_CTRL:     data_out = {16'd0, decay_period_q, 4'd0, ctrl_ovf_en_q, 1'b0,
                                       ctrl_learn_q, ctrl_enable_q};
            ADDR_STATUS:   data_out = {21'd0, irq_q, busy_q, overflow_q, 3'd0, 5'(fifo_count)};
            ADDR_POS:      data_out = {16'(pos_y_q), 16'(pos_x_q)};
            ADDR_GEOFENCE: data_out = {16'd0, geofence_q};
            default: begin
                if (ch_hit) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (ch_sel == 3'(i)) begin
                            data_out = {14'd0, heading_q[i], 16'(weight_q[i])};
                        end
                    end
                end
            end
        endcase
    end

endmodule
